// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ack instruction-memory port and IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_StallF,
    input  logic                     i_StallD,
    input  logic                     i_FlushD,
    input  logic                     i_PCSrcD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCNextD,
    output logic                     o_IMemReq,
    output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
    input  logic                     i_IMemAck,
    input  logic [INSTR_WIDTH-1:0]   i_IMemRData,
    output logic [ADDRESS_WIDTH-1:0] o_PCF,
    output logic                     o_FetchBusyF,
    output logic [INSTR_WIDTH-1:0]   o_InstrD,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
    output logic                     o_ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              o_FetchCount,
    output logic [31:0]              o_BubbleCount
`endif
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   state;
    logic                     started;
    logic [ADDRESS_WIDTH-1:0] pcf;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic [INSTR_WIDTH-1:0]   hold_instr;
    logic [ADDRESS_WIDTH-1:0] hold_pc4;

    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] target;
    logic                     req;
    logic                     ack;
    logic                     deliver;
    logic [INSTR_WIDTH-1:0]   deliver_instr;
    logic [ADDRESS_WIDTH-1:0] deliver_pc4;
    logic                     unused_target_bits;

    logic [INSTR_WIDTH-1:0]   instr_d;
    logic [ADDRESS_WIDTH-1:0] pc4_d;
    logic                     valid_d;

    assign target             = {i_PCNextD[ADDRESS_WIDTH-1:2], 2'b00};
    assign unused_target_bits = ^i_PCNextD[1:0];
    assign pc_plus4           = pcf + ADDRESS_WIDTH'(4);

    // The port stays quiet for the first cycle out of reset so a response
    // to a request abandoned by reset can never be mistaken for a new one.
    assign req = started && (state != S_HOLD);
    assign ack = req && i_IMemAck;

    always_comb begin
        deliver       = 1'b0;
        deliver_instr = '0;
        deliver_pc4   = '0;
        if (!i_PCSrcD && !i_StallF) begin
            if (state == S_REQ && ack) begin
                deliver       = 1'b1;
                deliver_instr = i_IMemRData;
                deliver_pc4   = pc_plus4;
            end else if (state == S_HOLD) begin
                deliver       = 1'b1;
                deliver_instr = hold_instr;
                deliver_pc4   = hold_pc4;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state       <= S_REQ;
            started     <= 1'b0;
            pcf         <= RESET_PC;
            redirect_pc <= '0;
            hold_instr  <= '0;
            hold_pc4    <= '0;
        end else begin
            started <= 1'b1;
            case (state)
                S_REQ: begin
                    if (ack) begin
                        if (i_PCSrcD) begin
                            pcf <= target;
                        end else if (i_StallF) begin
                            hold_instr <= i_IMemRData;
                            hold_pc4   <= pc_plus4;
                            state      <= S_HOLD;
                        end else begin
                            pcf <= pc_plus4;
                        end
                    end else if (i_PCSrcD) begin
                        // An outstanding request keeps its address until acked.
                        if (started) begin
                            redirect_pc <= target;
                            state       <= S_DRAIN;
                        end else begin
                            pcf <= target;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_PCSrcD) begin
                        pcf        <= target;
                        hold_instr <= '0;
                        hold_pc4   <= '0;
                        state      <= S_REQ;
                    end else if (!i_StallF) begin
                        pcf   <= pc_plus4;
                        state <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (ack) begin
                        pcf   <= i_PCSrcD ? target : redirect_pc;
                        state <= S_REQ;
                    end else if (i_PCSrcD) begin
                        redirect_pc <= target;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            instr_d <= '0;
            pc4_d   <= '0;
            valid_d <= 1'b0;
        end else if (i_StallD) begin
            instr_d <= instr_d;
        end else if (i_FlushD || !deliver) begin
            instr_d <= '0;
            pc4_d   <= '0;
            valid_d <= 1'b0;
        end else begin
            instr_d <= deliver_instr;
            pc4_d   <= deliver_pc4;
            valid_d <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
    logic        load_instr;
    logic        load_bubble;

    assign load_instr  = deliver && !i_FlushD && !i_StallD;
    assign load_bubble = !i_StallD && !load_instr;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (load_instr) fetch_count <= fetch_count + 32'd1;
            if (load_bubble) bubble_count <= bubble_count + 32'd1;
        end
    end

    assign o_FetchCount  = fetch_count;
    assign o_BubbleCount = bubble_count;
`endif

    assign o_IMemReq    = req;
    assign o_IMemAddr   = {pcf[ADDRESS_WIDTH-1:2], 2'b00};
    assign o_PCF        = pcf;
    assign o_FetchBusyF = req && !i_IMemAck;
    assign o_InstrD     = instr_d;
    assign o_PCPlus4D   = pc4_d;
    assign o_ValidD     = valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero/two-wait memory, stall hold, redirect drain, flush, PC wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f, stall_d, flush_d, pcsrc_d;
    logic [31:0] pc_next_d;

    logic        mem_req, mem_ack, busy, valid_d;
    logic [31:0] mem_addr, mem_rdata, pcf, instr_d, pc4_d;

    logic        w_req, w_ack, w_busy, w_valid;
    logic [31:0] w_addr, w_rdata, w_pcf, w_instr, w_pc4;

    int wait_states;
    int wait_cnt;
    int compared;
    int mismatched;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, bubble_count, w_fetch_count, w_bubble_count;
    logic [31:0] fetch_before, bubble_before;
`endif

    always #5 clk = ~clk;

    // Memory model: acks after wait_states idle cycles, data = 0x2000_0000 + address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 0;
        else if (!mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    assign mem_ack   = mem_req && (wait_cnt >= wait_states);
    assign mem_rdata = mem_ack ? 32'h2000_0000 + mem_addr : 32'hDEAD_BEEF;
    assign w_ack     = w_req;
    assign w_rdata   = 32'h2000_0000 + w_addr;

    fetch_stage dut (
        .i_CLK        (clk),
        .i_RST        (rst_n),
        .i_StallF     (stall_f),
        .i_StallD     (stall_d),
        .i_FlushD     (flush_d),
        .i_PCSrcD     (pcsrc_d),
        .i_PCNextD    (pc_next_d),
        .o_IMemReq    (mem_req),
        .o_IMemAddr   (mem_addr),
        .i_IMemAck    (mem_ack),
        .i_IMemRData  (mem_rdata),
        .o_PCF        (pcf),
        .o_FetchBusyF (busy),
        .o_InstrD     (instr_d),
        .o_PCPlus4D   (pc4_d),
        .o_ValidD     (valid_d)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_FetchCount (fetch_count),
        .o_BubbleCount(bubble_count)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .i_CLK        (clk),
        .i_RST        (rst_n),
        .i_StallF     (1'b0),
        .i_StallD     (1'b0),
        .i_FlushD     (1'b0),
        .i_PCSrcD     (1'b0),
        .i_PCNextD    (32'h0),
        .o_IMemReq    (w_req),
        .o_IMemAddr   (w_addr),
        .i_IMemAck    (w_ack),
        .i_IMemRData  (w_rdata),
        .o_PCF        (w_pcf),
        .o_FetchBusyF (w_busy),
        .o_InstrD     (w_instr),
        .o_PCPlus4D   (w_pc4),
        .o_ValidD     (w_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_FetchCount (w_fetch_count),
        .o_BubbleCount(w_bubble_count)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sf, input logic sd, input logic fl, input logic ps,
                                 input logic [31:0] tgt);
        stall_f   = sf;
        stall_d   = sd;
        flush_d   = fl;
        pcsrc_d   = ps;
        pc_next_d = tgt;
        #1;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        wait_states = 0;
        rst_n       = 1'b0;
        applyStimulus(0, 0, 0, 0, 32'h0);
        stepCycle();
        stepCycle();

        checkOutput("reset_req",   {31'b0, mem_req}, 32'h0);
        checkOutput("reset_pcf",   pcf,              32'h0);
        checkOutput("reset_instr", instr_d,          32'h0);
        checkOutput("reset_pc4",   pc4_d,            32'h0);
        checkOutput("reset_valid", {31'b0, valid_d}, 32'h0);
        checkOutput("reset_wpcf",  w_pcf,            32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("reset_fetch_cnt",  fetch_count,  32'h0);
        checkOutput("reset_bubble_cnt", bubble_count, 32'h0);
`endif

        rst_n = 1'b1;
        stepCycle();
        checkOutput("first_req",   {31'b0, mem_req}, 32'h1);
        checkOutput("addr0",       mem_addr,         32'h0);
        checkOutput("waddr0",      w_addr,           32'hFFFF_FFFC);
        stepCycle();
        checkOutput("instr0",      instr_d,          32'h2000_0000);
        checkOutput("pc4_0",       pc4_d,            32'h4);
        checkOutput("valid0",      {31'b0, valid_d}, 32'h1);
        checkOutput("addr4",       mem_addr,         32'h4);
        checkOutput("waddr_wrap",  w_addr,           32'h0);
        checkOutput("wpc4_wrap",   w_pc4,            32'h0);
        checkOutput("winstr",      w_instr,          32'h1FFF_FFFC);
        stepCycle();
        checkOutput("instr1",      instr_d,          32'h2000_0004);
        checkOutput("pc4_1",       pc4_d,            32'h8);
        checkOutput("addr8",       mem_addr,         32'h8);

        wait_states = 2;
        #1;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("ws2_busy%0d", k), {31'b0, busy}, {31'b0, (k % 3) != 2});
            stepCycle();
            checkOutput($sformatf("ws2_valid%0d", k), {31'b0, valid_d}, {31'b0, (k % 3) == 2});
        end
        checkOutput("ws2_instr",   instr_d,          32'h2000_000C);
        checkOutput("ws2_pc4",     pc4_d,            32'h10);
        checkOutput("ws2_addr",    mem_addr,         32'h10);

        wait_states = 0;
        applyStimulus(1, 1, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput($sformatf("stall_req%0d", k),   {31'b0, mem_req}, 32'h0);
            checkOutput($sformatf("stall_instr%0d", k), instr_d,          32'h2000_000C);
            checkOutput($sformatf("stall_valid%0d", k), {31'b0, valid_d}, 32'h1);
        end
        applyStimulus(0, 0, 0, 0, 32'h0);
        stepCycle();
        checkOutput("release_instr", instr_d,          32'h2000_0010);
        checkOutput("release_pc4",   pc4_d,            32'h14);
        checkOutput("release_addr",  mem_addr,         32'h14);
        checkOutput("release_req",   {31'b0, mem_req}, 32'h1);

        applyStimulus(0, 0, 0, 1, 32'h8);
        stepCycle();
        checkOutput("redir_ack_valid", {31'b0, valid_d}, 32'h0);
        checkOutput("redir_ack_addr",  mem_addr,         32'h8);

        wait_states = 2;
        applyStimulus(0, 0, 0, 1, 32'h403);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("drain_addr_a",  mem_addr,         32'h8);
        checkOutput("drain_busy_a",  {31'b0, busy},    32'h1);
        checkOutput("drain_valid_a", {31'b0, valid_d}, 32'h0);
        stepCycle();
        checkOutput("drain_addr_b",  mem_addr,         32'h8);
        checkOutput("drain_busy_b",  {31'b0, busy},    32'h0);
        checkOutput("drain_valid_b", {31'b0, valid_d}, 32'h0);
        stepCycle();
        checkOutput("drain_target",  mem_addr,         32'h400);
        checkOutput("drain_valid_c", {31'b0, valid_d}, 32'h0);

        wait_states = 0;
`ifdef FETCH_PERF_CNT_EN
        fetch_before  = fetch_count;
        bubble_before = bubble_count;
`endif
        applyStimulus(0, 0, 1, 0, 32'h0);
        stepCycle();
        checkOutput("flush_instr", instr_d,          32'h0);
        checkOutput("flush_valid", {31'b0, valid_d}, 32'h0);
        checkOutput("flush_pc4",   pc4_d,            32'h0);
        checkOutput("flush_addr",  mem_addr,         32'h404);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("flush_bubble_cnt", bubble_count, bubble_before + 32'd1);
        checkOutput("flush_fetch_cnt",  fetch_count,  fetch_before);
`endif
        applyStimulus(0, 0, 0, 0, 32'h0);
        stepCycle();
        checkOutput("post_flush_instr", instr_d, 32'h2000_0404);
        checkOutput("post_flush_pc4",   pc4_d,   32'h408);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("post_flush_fetch_cnt", fetch_count, fetch_before + 32'd1);
`endif

        wait_states = 2;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_req",  {31'b0, mem_req}, 32'h0);
        checkOutput("midreset_addr", mem_addr,         32'h0);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("restart_req",   {31'b0, mem_req}, 32'h1);
        checkOutput("restart_addr",  mem_addr,         32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter, issues word reads to instruction memory over a req/ack handshake that tolerates wait states, and loads the IF/ID pipeline register (instruction, PC+4, valid) consumed by decode. Accepts branch/jump redirects (target and select) resolved in decode, plus stall/flush controls from the hazard unit.

## Interface
- `ADDRESS_WIDTH`, 32: PC / memory address width.
- `INSTR_WIDTH`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: PC value after reset.

- `i_CLK`  in  1  single clock; all state updates on the rising edge.
- `i_RST`  in  1  asynchronous, active-low reset.
- `i_StallF`  in  1  hazard unit: hold PC / do not deliver to IF/ID.
- `i_StallD`  in  1  hazard unit: hold IF/ID. Guaranteed to be asserted only while `i_StallF` is also asserted.
- `i_FlushD`  in  1  hazard unit: clear IF/ID to a bubble.
- `i_PCSrcD`  in  1  decode: redirect fetch to `i_PCNextD`.
- `i_PCNextD`  in  ADDRESS_WIDTH  redirect target; bits [1:0] ignored.
- `o_IMemReq`  out  1  instruction read request.
- `o_IMemAddr`  out  ADDRESS_WIDTH  word address, always `{PCF[AW-1:2],2'b00}`.
- `i_IMemAck`  in  1  read complete; data valid in the same cycle.
- `i_IMemRData`  in  INSTR_WIDTH  read data.
- `o_PCF`  out  ADDRESS_WIDTH  current fetch PC.
- `o_FetchBusyF`  out  1  request outstanding, no ack this cycle.
- `o_InstrD`  out  INSTR_WIDTH  IF/ID instruction.
- `o_PCPlus4D`  out  ADDRESS_WIDTH  IF/ID PC+4.
- `o_ValidD`  out  1  IF/ID holds a real instruction.

## Operation
- FSM states:
  - S_REQ: request outstanding.
  - S_HOLD: fetched word buffered, waiting for the stall to release.
  - S_DRAIN: request outstanding but already redirected; its response is discarded.
- `o_IMemReq` = 1 in S_REQ and S_DRAIN, 0 in S_HOLD and during reset.
- `o_IMemAddr` holds stable from request until ack.
- **S_REQ**
  - ack & `i_PCSrcD`: discard data; PCF ← target; stay in S_REQ.
  - ack & !redirect & `i_StallF`: capture data and PC+4 into the hold buffer; go to S_HOLD.
  - ack & !redirect & !`i_StallF`: deliver; PCF ← PCF+4; stay in S_REQ.
  - !ack & `i_PCSrcD`: latch target into the redirect register; go to S_DRAIN. PCF is not changed, so the address stays stable.
- **S_HOLD**
  - `i_PCSrcD`: drop the buffer; PCF ← target; go to S_REQ.
  - else !`i_StallF`: deliver the buffer; PCF ← PCF+4; go to S_REQ.
  - else: stay.
- **S_DRAIN**
  - ack: discard data; PCF ← redirect register; go to S_REQ.
  - A further `i_PCSrcD` before the ack overwrites the redirect register (last redirect wins).
- **IF/ID update priority:**
  1. `i_StallD`: hold.
  2. `i_FlushD`: `o_InstrD`=0 (NOP), `o_ValidD`=0, `o_PCPlus4D`=0.
  3. Delivery: load instruction and PC+4; `o_ValidD`=1.
  4. Otherwise: bubble (same values as flush).
- Redirect takes priority over `i_StallF` for PC update.
- PC+4 wraps modulo 2^ADDRESS_WIDTH.
- `o_FetchBusyF` = (S_REQ | S_DRAIN) & !`i_IMemAck`.

## Timing
- Reset (async assert) values:
  - PCF = `RESET_PC`, state = S_REQ, redirect register = 0, hold buffer = 0.
  - `o_InstrD`=0, `o_PCPlus4D`=0, `o_ValidD`=0, `o_IMemReq`=0.
- First request is asserted in the first cycle after reset deassertion.
- Zero-wait memory (ack in the request cycle): one instruction per cycle. Instruction appears on `o_InstrD` the cycle after its ack.
- N wait states: N bubbles per instruction.
- Redirect in cycle t with no outstanding request: first request to the target appears in cycle t+1.
- Redirect during an outstanding request: request to the target appears the cycle after the old ack.
- Reset mid-request: the response is abandoned. Memory must tolerate a dropped request.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `o_FetchCount` and `o_BubbleCount`, both 32-bit, reset to 0, wrapping.
  - `o_FetchCount` increments on each delivery.
  - `o_BubbleCount` increments on each cycle IF/ID loads a bubble, including flush; stall cycles do not count.
- Undefined: these ports and counters are absent.

## Test plan
- Reset release, zero-wait memory returning `0x2000_0000+addr`:
  - `o_IMemAddr` sequence 0,4,8.
  - `o_InstrD` = 0x2000_0000, 0x2000_0004… from cycle 2.
  - `o_PCPlus4D` = 4, 8…
- Memory with 2 wait states: `o_ValidD` pattern 0,0,1 repeating; `o_FetchBusyF` high for 2 of every 3 cycles.
- `i_StallF`=`i_StallD`=1 for 3 cycles on an ack at PC 0x10:
  - FSM goes to S_HOLD; IF/ID is held.
  - On release, IF/ID = instruction at 0x10 and `o_PCPlus4D`=0x14.
  - Next request is 0x14.
- `i_PCSrcD`=1 with target 0x400 while the request at 0x8 waits 2 cycles: `o_IMemAddr` stays 0x8 until ack, data is discarded, next address is 0x400.
- `i_FlushD` with delivery in the same cycle: `o_InstrD`=0, `o_ValidD`=0. With `FETCH_PERF_CNT_EN`, `o_BubbleCount` increments.
- `RESET_PC`=0xFFFF_FFFC: second request address wraps to 0x0.
